// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: an untagged BHT of 2-bit counters plus a tagged BTB,
// with a one-cycle registered lookup port and an independent training port from execute.
module branch_predictor #(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pred_valid,
   input  logic [63:0] pred_pc,
   output logic        pred_out_valid,
   output logic        pred_taken,
   output logic [63:0] pred_target,
   input  logic        upd_valid,
   input  logic [63:0] upd_pc,
   input  logic        upd_taken,
   input  logic [63:0] upd_target,
   output logic [31:0] perf_miss
);

   localparam int IDX_W   = $clog2(ENTRIES);
   localparam int TAG_LSB = IDX_W + 2;
   localparam int TAG_MSB = IDX_W + TAG_W + 1;

   logic [1:0]         bhtCtr_q    [ENTRIES];
   logic [ENTRIES-1:0] btbValid_q;
   logic [TAG_W-1:0]   btbTag_q    [ENTRIES];
   logic [63:0]        btbTarget_q [ENTRIES];

   logic               predOutValid_q, predOutValid_d;
   logic               predTaken_q, predTaken_d;
   logic [63:0]        predTarget_q, predTarget_d;
   logic [31:0]        perfMiss_q, perfMiss_d;

   logic [IDX_W-1:0]   predIdx;
   logic [TAG_W-1:0]   predTag;
   logic [1:0]         lookupCtr;
   logic               lookupHit;
   logic               lookupTaken;

   logic [IDX_W-1:0]   updIdx;
   logic [TAG_W-1:0]   updTag;
   logic [1:0]         updCtr;
   logic [1:0]         updCtrNext;
   logic               dirMiss;

   logic               unusedPcBits;

   assign predIdx = pred_pc[IDX_W+1:2];
   assign predTag = pred_pc[TAG_MSB:TAG_LSB];
   assign updIdx  = upd_pc[IDX_W+1:2];
   assign updTag  = upd_pc[TAG_MSB:TAG_LSB];

   // Byte offset and PC bits above the tag never take part in indexing or matching.
   assign unusedPcBits = ^{pred_pc[1:0], pred_pc[63:TAG_MSB+1],
                           upd_pc[1:0], upd_pc[63:TAG_MSB+1]};

   // Lookup reads the tables as they stand before this edge's update (read-before-write).
   always_comb begin
      lookupCtr   = bhtCtr_q[predIdx];
      lookupHit   = btbValid_q[predIdx] && (btbTag_q[predIdx] == predTag);
      lookupTaken = lookupCtr[1] && lookupHit;

      predOutValid_d = pred_valid;
      predTaken_d    = predTaken_q;
      predTarget_d   = predTarget_q;
      if (pred_valid) begin
         predTaken_d  = lookupTaken;
         predTarget_d = lookupTaken ? btbTarget_q[predIdx] : pred_pc + 64'd4;
      end
   end

   always_comb begin
      updCtr     = bhtCtr_q[updIdx];
      updCtrNext = updCtr;
      if (upd_taken) begin
         if (updCtr != 2'd3) begin
            updCtrNext = updCtr + 2'd1;
         end
      end else begin
         if (updCtr != 2'd0) begin
            updCtrNext = updCtr - 2'd1;
         end
      end

      // A miss is judged against the counter's direction before this update trains it.
      dirMiss    = upd_valid && (updCtr[1] != upd_taken);
      perfMiss_d = perfMiss_q;
      if (dirMiss && (perfMiss_q != 32'hFFFF_FFFF)) begin
         perfMiss_d = perfMiss_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         predOutValid_q <= 1'b0;
         predTaken_q    <= 1'b0;
         predTarget_q   <= 64'h0;
         perfMiss_q     <= 32'h0;
      end else begin
         predOutValid_q <= predOutValid_d;
         predTaken_q    <= predTaken_d;
         predTarget_q   <= predTarget_d;
         perfMiss_q     <= perfMiss_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bhtCtr_q[i] <= 2'b01;
         end
         btbValid_q <= '0;
      end else if (upd_valid) begin
         bhtCtr_q[updIdx] <= updCtrNext;
         if (upd_taken) begin
            btbValid_q[updIdx] <= 1'b1;
         end
      end
   end

   // BTB payload is qualified by btbValid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (upd_valid && upd_taken) begin
         btbTag_q[updIdx]    <= updTag;
         btbTarget_q[updIdx] <= upd_target;
      end
   end

   assign pred_out_valid = predOutValid_q;
   assign pred_taken     = predTaken_q;
   assign pred_target    = predTarget_q;
   assign perf_miss      = perfMiss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor: each scenario task drives vectors and
// compares the registered outputs against hand-computed values.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic        pred_valid;
   logic [63:0] pred_pc;
   logic        pred_out_valid;
   logic        pred_taken;
   logic [63:0] pred_target;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_taken;
   logic [63:0] upd_target;
   logic [31:0] perf_miss;

   int vectors;
   int miscompares;

   branch_predictor #(.ENTRIES(64), .TAG_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pred_valid     (pred_valid),
      .pred_pc        (pred_pc),
      .pred_out_valid (pred_out_valid),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .perf_miss      (perf_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of stimulus from a falling edge and returns at the next falling
   // edge with both ports idle, so the captured outputs can be sampled directly.
   task automatic applyStimulus(input logic pv, input logic [63:0] ppc,
                                input logic uv, input logic [63:0] upc,
                                input logic ut, input logic [63:0] utgt);
      pred_valid = pv;
      pred_pc    = ppc;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_target = utgt;
      @(negedge clk);
      pred_valid = 1'b0;
      upd_valid  = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (pred_out_valid !== 1'b0 || pred_target !== 64'h0 || pred_taken !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got valid=%b taken=%b target=%h, expected 0/0/0",
                  pred_out_valid, pred_taken, pred_target);
      end
      applyStimulus(1'b1, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h8000_0004) begin
         miscompares++;
         $display("[TB] FAIL reset_lookup: got valid=%b taken=%b target=%h, expected 1/0/80000004",
                  pred_out_valid, pred_taken, pred_target);
      end
      vectors++;
      if (perf_miss !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_perf: got %0d expected 0", perf_miss);
      end
   endtask

   task automatic test_train_taken;
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
      vectors++;
      if (perf_miss !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL first_taken_perf: got %0d expected 1", perf_miss);
      end
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h8000_0100) begin
         miscompares++;
         $display("[TB] FAIL first_taken_lookup: got valid=%b taken=%b target=%h, expected 1/1/80000100",
                  pred_out_valid, pred_taken, pred_target);
      end
   endtask

   task automatic test_hysteresis;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
      end
      vectors++;
      if (perf_miss !== 32'd1) begin
         miscompares++;
         $display("[TB] FAIL saturate_taken_perf: got %0d expected 1", perf_miss);
      end
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b0, 64'h0);
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0100 || perf_miss !== 32'd2) begin
         miscompares++;
         $display("[TB] FAIL weak_taken: got taken=%b target=%h perf=%0d, expected 1/80000100/2",
                  pred_taken, pred_target, perf_miss);
      end
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b0, 64'h0);
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b0, 64'h0);
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0014 || perf_miss !== 32'd3) begin
         miscompares++;
         $display("[TB] FAIL strong_not_taken: got taken=%b target=%h perf=%0d, expected 0/80000014/3",
                  pred_taken, pred_target, perf_miss);
      end
   endtask

   task automatic test_alias;
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_0100);
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0100 || perf_miss !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL retrain: got taken=%b target=%h perf=%0d, expected 1/80000100/5",
                  pred_taken, pred_target, perf_miss);
      end
      applyStimulus(1'b1, 64'h8000_0110, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0114) begin
         miscompares++;
         $display("[TB] FAIL alias_tag_miss: got taken=%b target=%h, expected 0/80000114",
                  pred_taken, pred_target);
      end
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0110, 1'b1, 64'h8000_0200);
      applyStimulus(1'b1, 64'h8000_0110, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b1 || pred_target !== 64'h8000_0200 || perf_miss !== 32'd5) begin
         miscompares++;
         $display("[TB] FAIL alias_replace: got taken=%b target=%h perf=%0d, expected 1/80000200/5",
                  pred_taken, pred_target, perf_miss);
      end
      applyStimulus(1'b1, 64'h8000_0010, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_taken !== 1'b0 || pred_target !== 64'h8000_0014) begin
         miscompares++;
         $display("[TB] FAIL alias_evicted: got taken=%b target=%h, expected 0/80000014",
                  pred_taken, pred_target);
      end
   endtask

   task automatic test_back_to_back;
      applyStimulus(1'b1, 64'h8000_0020, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0300);
      vectors++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h8000_0024) begin
         miscompares++;
         $display("[TB] FAIL same_cycle_rbw: got valid=%b taken=%b target=%h, expected 1/0/80000024",
                  pred_out_valid, pred_taken, pred_target);
      end
      applyStimulus(1'b1, 64'h8000_0020, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 64'h8000_0300 ||
          perf_miss !== 32'd6) begin
         miscompares++;
         $display("[TB] FAIL next_cycle_visible: got valid=%b taken=%b target=%h perf=%0d, expected 1/1/80000300/6",
                  pred_out_valid, pred_taken, pred_target, perf_miss);
      end
      applyStimulus(1'b0, 64'h8000_0000, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_out_valid !== 1'b0 || pred_taken !== 1'b1 || pred_target !== 64'h8000_0300) begin
         miscompares++;
         $display("[TB] FAIL idle_hold: got valid=%b taken=%b target=%h, expected 0/1/80000300",
                  pred_out_valid, pred_taken, pred_target);
      end
   endtask

   task automatic test_reset_midflight;
      pred_valid = 1'b1;
      pred_pc    = 64'h8000_0020;
      #2 rst_n = 1'b0;
      @(negedge clk);
      pred_valid = 1'b0;
      vectors++;
      if (pred_out_valid !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 64'h0 ||
          perf_miss !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL midflight_reset: got valid=%b taken=%b target=%h perf=%0d, expected 0/0/0/0",
                  pred_out_valid, pred_taken, pred_target, perf_miss);
      end
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1, 64'h8000_0020, 1'b0, 64'h0, 1'b0, 64'h0);
      vectors++;
      if (pred_out_valid !== 1'b1 || pred_taken !== 1'b0 || pred_target !== 64'h8000_0024) begin
         miscompares++;
         $display("[TB] FAIL forgotten_entry: got valid=%b taken=%b target=%h, expected 1/0/80000024",
                  pred_out_valid, pred_taken, pred_target);
      end
   endtask

   task automatic test_perf_saturation;
      force dut.perfMiss_q = 32'hFFFF_FFFE;
      #1 release dut.perfMiss_q;
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0300);
      vectors++;
      if (perf_miss !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("[TB] FAIL perf_reach_max: got %h expected ffffffff", perf_miss);
      end
      applyStimulus(1'b0, 64'h0, 1'b1, 64'h8000_0020, 1'b0, 64'h0);
      vectors++;
      if (perf_miss !== 32'hFFFF_FFFF) begin
         miscompares++;
         $display("[TB] FAIL perf_saturate: got %h expected ffffffff", perf_miss);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b1;
      pred_valid  = 1'b0;
      pred_pc     = 64'h0;
      upd_valid   = 1'b0;
      upd_pc      = 64'h0;
      upd_taken   = 1'b0;
      upd_target  = 64'h0;
      @(negedge clk);
      test_reset;
      test_train_taken;
      test_hysteresis;
      test_alias;
      test_back_to_back;
      test_reset_midflight;
      test_perf_saturation;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
